// File: rtl/manchester_spi_tx.sv
// Manchester-encoded serial transmitter with forwarded bit clock,
// optional even parity, inter-frame gap and synchronous abort.
module manchester_spi_tx #(
   parameter int DATA_W     = 8,
   parameter int MSB_FIRST  = 0,
   parameter int PARITY_EN  = 0,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              abort,
   output logic              out,
   output logic              en_out,
   output logic              clk_out,
   output logic              sent
);

   localparam int N  = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    sh_q, sh_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            half_q, half_d;
   logic [7:0]      gap_q, gap_d;
   logic            out_d, en_d, clko_d, sent_d, rdy_d;
   logic [N-1:0]    frame;

   // Bit 0 of the shift register is always the bit currently on the line.
   always_comb begin
      frame = '0;
      for (int i = 0; i < DATA_W; i++) begin
         frame[i] = (MSB_FIRST != 0) ? in_data[DATA_W-1-i] : in_data[i];
      end
      if (PARITY_EN != 0) begin
         frame[N-1] = ^in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      gap_d   = gap_q;
      out_d   = 1'b0;
      en_d    = 1'b0;
      clko_d  = 1'b0;
      sent_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready && !abort) begin
               state_d = SEND;
               sh_d    = frame;
               cnt_d   = '0;
               half_d  = 1'b0;
               out_d   = frame[0];
               en_d    = 1'b1;
            end
         end
         SEND: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               half_d  = 1'b0;
            end else if (!half_q) begin
               half_d = 1'b1;
               out_d  = ~sh_q[0];
               en_d   = 1'b1;
               clko_d = 1'b1;
            end else if (cnt_q == LAST) begin
               sent_d  = 1'b1;
               half_d  = 1'b0;
               cnt_d   = '0;
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               sh_d   = sh_q >> 1;
               half_d = 1'b0;
               out_d  = sh_q[1];
               en_d   = 1'b1;
            end
         end
         GAP: begin
            if (abort || gap_q == GAP_LAST) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         cnt_q    <= '0;
         half_q   <= 1'b0;
         gap_q    <= '0;
         out      <= 1'b0;
         en_out   <= 1'b0;
         clk_out  <= 1'b0;
         sent     <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         gap_q    <= gap_d;
         out      <= out_d;
         en_out   <= en_d;
         clk_out  <= clko_d;
         sent     <= sent_d;
         in_ready <= rdy_d;
      end
   end

endmodule

// File: tb/tb_manchester_spi_tx.sv
// Bench for manchester_spi_tx: four configurations side by side,
// table-driven frames with a queue scoreboard plus corner sequences.
module tb_manchester_spi_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d  [4];
   logic       v  [4];
   logic       ab [4];
   logic       o  [4];
   logic       en [4];
   logic       co [4];
   logic       st [4];
   logic       rdy[4];

   int checks = 0;
   int errors = 0;
   logic q[$];

   always #5 clk = ~clk;

   // 0: defaults, 1: MSB first, 2: parity, 3: gap of 2
   for (genvar k = 0; k < 4; k++) begin : g_dut
      manchester_spi_tx #(
         .DATA_W(8),
         .MSB_FIRST((k == 1) ? 1 : 0),
         .PARITY_EN((k == 2) ? 1 : 0),
         .GAP_CYCLES((k == 3) ? 2 : 0)
      ) dut (
         .clk(clk),
         .rst(rst),
         .in_data(d[k]),
         .in_valid(v[k]),
         .in_ready(rdy[k]),
         .abort(ab[k]),
         .out(o[k]),
         .en_out(en[k]),
         .clk_out(co[k]),
         .sent(st[k])
      );
   end

   typedef struct {
      int         k;
      logic [7:0] data;
      logic [17:0] pat;
      int         len;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_rdy(input int k);
      int n;
      n = 0;
      while (!rdy[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) chk("ready_timeout", 0, 1);
   endtask

   task automatic run_vec(input vec_t t);
      logic b;
      wait_rdy(t.k);
      d[t.k] = t.data;
      v[t.k] = 1'b1;
      @(posedge clk);
      for (int i = 0; i < t.len; i++) q.push_back(t.pat[17-i]);
      @(negedge clk);
      v[t.k] = 1'b0;
      d[t.k] = ~t.data;
      for (int i = 0; i < t.len; i++) begin
         b = q.pop_front();
         chk("en_out", 32'(en[t.k]), 1);
         chk("out", 32'(o[t.k]), 32'(b));
         chk("clk_out", 32'(co[t.k]), 32'(i % 2));
         chk("in_ready_busy", 32'(rdy[t.k]), 0);
         chk("sent_early", 32'(st[t.k]), 0);
         @(negedge clk);
      end
      chk("en_out_end", 32'(en[t.k]), 0);
      chk("out_idle", 32'(o[t.k]), 0);
      chk("sent", 32'(st[t.k]), 1);
      @(negedge clk);
      chk("sent_pulse", 32'(st[t.k]), 0);
   endtask

   initial begin
      int cyc, t1, t2, lowcnt, nst;
      vt[0] = '{0, 8'hA5, 18'b100110010110011000, 16};
      vt[1] = '{1, 8'h80, 18'b100101010101010100, 16};
      vt[2] = '{2, 8'h07, 18'b101010010101010110, 18};
      vt[3] = '{3, 8'h3C, 18'b010110101010010100, 16};
      vt[4] = '{0, 8'h00, 18'b010101010101010100, 16};
      vt[5] = '{0, 8'hFF, 18'b101010101010101000, 16};
      for (int k = 0; k < 4; k++) begin
         d[k] = '0; v[k] = 1'b0; ab[k] = 1'b0;
      end

      #1;
      chk("rst_out", 32'(o[0]), 0);
      chk("rst_en", 32'(en[0]), 0);
      chk("rst_ready", 32'(rdy[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_before_edge", 32'(rdy[0]), 0);
      @(negedge clk);
      chk("ready_after_edge", 32'(rdy[0]), 1);

      foreach (vt[i]) run_vec(vt[i]);

      // back-to-back with gap: transfer edges must be 19 cycles apart
      wait_rdy(3);
      d[3] = 8'h5A; v[3] = 1'b1;
      cyc = 0; t1 = -1; t2 = -1; lowcnt = 0;
      while (t2 < 0 && cyc < 60) begin
         if (rdy[3]) begin
            if (t1 < 0) t1 = cyc; else t2 = cyc;
         end else if (t1 >= 0) begin
            lowcnt++;
         end
         @(negedge clk);
         cyc++;
      end
      v[3] = 1'b0;
      chk("gap_spacing", 32'(t2 - t1), 19);
      chk("gap_ready_low", 32'(lowcnt), 18);
      repeat (25) @(negedge clk);

      // abort during the 5th frame cycle
      wait_rdy(0);
      d[0] = 8'hA5; v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_pre_en", 32'(en[0]), 1);
      ab[0] = 1'b1;
      @(negedge clk);
      ab[0] = 1'b0;
      chk("abort_en", 32'(en[0]), 0);
      chk("abort_out", 32'(o[0]), 0);
      chk("abort_clk_out", 32'(co[0]), 0);
      chk("abort_idle", 32'(rdy[0]), 1);
      nst = 0;
      for (int i = 0; i < 20; i++) begin
         if (st[0]) nst++;
         @(negedge clk);
      end
      chk("abort_no_sent", 32'(nst), 0);

      // abort together with in_valid in IDLE blocks the transfer
      ab[0] = 1'b1; v[0] = 1'b1; d[0] = 8'hFF;
      @(negedge clk);
      ab[0] = 1'b0; v[0] = 1'b0;
      chk("abort_idle_block", 32'(en[0]), 0);
      chk("abort_idle_ready", 32'(rdy[0]), 1);

      // asynchronous reset mid-frame while out is high
      d[0] = 8'hFF; v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      chk("pre_rst_out", 32'(o[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_out", 32'(o[0]), 0);
      chk("async_en", 32'(en[0]), 0);
      chk("async_clk_out", 32'(co[0]), 0);
      chk("async_ready", 32'(rdy[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rel_ready_0", 32'(rdy[0]), 0);
      @(posedge clk);
      #1 chk("rel_ready_1", 32'(rdy[0]), 1);
      nst = 0;
      for (int i = 0; i < 20; i++) begin
         if (st[0] || en[0]) nst++;
         @(negedge clk);
      end
      chk("rst_discard", 32'(nst), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
